// File: rtl/present_decrypt.sv
// PRESENT-80 block decryptor: expands the user key forward to K32, then peels off
// 31 inverse rounds while walking the key schedule back down to K1.
module present_decrypt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        chip_enable,
  input  logic        load,
  input  logic [63:0] idat,
  input  logic [79:0] key,
  output logic [63:0] odat,
  output logic        done,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for load, odat holds last result
  // KEXP  | forward key schedule, rc = 1..31, ends with kreg = K32
  // DEC   | one inverse round per cycle, rc = 31..1, ends with kreg = K1
  // FIN   | final whitening with K1, pulse done
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] KEXP = 2'd1;
  localparam logic [1:0] DEC  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]  state;
  logic [4:0]  rc;
  logic [63:0] dreg;
  logic [79:0] kreg;
  logic        done_q;

  logic [79:0] k_rot;
  logic [79:0] k_unx;
  logic [79:0] kreg_fwd;
  logic [79:0] kreg_inv;
  logic [63:0] dreg_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
    endcase
  endfunction

  // Inverse permutation (bit j -> 4j mod 63, bit 63 fixed) followed by inverse S-layer.
  function automatic logic [63:0] inv_round(input logic [63:0] x);
    logic [63:0] p;
    logic [63:0] r;
    p = '0;
    for (int j = 0; j < 63; j++) begin
      p[6'((4 * j) % 63)] = x[j];
    end
    p[63] = x[63];
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = inv_sbox(p[4*i +: 4]);
    end
    return r;
  endfunction

  always_comb begin
    k_rot = {kreg[18:0], kreg[79:19]};
    kreg_fwd = k_rot;
    kreg_fwd[79:76] = sbox(k_rot[79:76]);
    kreg_fwd[19:15] = k_rot[19:15] ^ rc;

    k_unx = kreg;
    k_unx[19:15] = kreg[19:15] ^ rc;
    k_unx[79:76] = inv_sbox(kreg[79:76]);
    kreg_inv = {k_unx[60:0], k_unx[79:61]};

    dreg_next = inv_round(dreg ^ kreg[79:16]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rc     <= 5'd0;
      dreg   <= 64'd0;
      kreg   <= 80'd0;
      odat   <= 64'd0;
      done_q <= 1'b0;
      busy   <= 1'b0;
    end else if (chip_enable) begin
      done_q <= 1'b0;
      if (load) begin
        dreg  <= idat;
        kreg  <= key;
        rc    <= 5'd1;
        odat  <= 64'd0;
        busy  <= 1'b1;
        state <= KEXP;
      end else begin
        case (state)
          KEXP: begin
            kreg <= kreg_fwd;
            if (rc == 5'd31) begin
              state <= DEC;
              rc    <= 5'd31;
            end else begin
              rc <= rc + 5'd1;
            end
          end
          DEC: begin
            dreg <= dreg_next;
            kreg <= kreg_inv;
            rc   <= rc - 5'd1;
            if (rc == 5'd1) state <= FIN;
          end
          FIN: begin
            odat   <= dreg ^ kreg[79:16];
            done_q <= 1'b1;
            state  <= IDLE;
          end
          default: busy <= 1'b0;
        endcase
      end
    end
  end

  // A pending pulse is held across disabled cycles and shown on the first enabled one.
  assign done = done_q & chip_enable;

endmodule

// File: doc/present_decrypt.md
PRESENT_DECRYPT -- requirements
Module: PRESENT_DECRYPT

Interface
REQ-001 Parameters: none; fixed PRESENT-80 (64-bit block, 80-bit key, 31 rounds).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 chip_enable  input  1  block enable; low freezes all state.
REQ-005 load  input  1  start strobe, sampled when chip_enable=1.
REQ-006 idat  input  64  ciphertext, captured on load.
REQ-007 key  input  80  user key (same key given to the encryptor), captured on load.
REQ-008 odat  output  64  recovered plaintext.
REQ-009 done  output  1  one-cycle pulse when odat becomes valid.
REQ-010 busy  output  1  high from the cycle after load until the done cycle, inclusive.

Function
REQ-011 The FSM SHALL have states IDLE, KEXP, DEC and FIN; the round counter rc SHALL be 5 bits.
REQ-012 When chip_enable=1 and load=1, in any state: dreg<=idat, kreg<=key, rc<=1, done<=0, odat<=0, state<=KEXP.
REQ-013 KEXP SHALL run the forward key update once per cycle for rc=1..31: rotate kreg left 61, replace [79:76] with S(top nibble), XOR [19:15] with rc, then rc<=rc+1.
REQ-014 When rc=31 in KEXP (kreg becomes K32), the block SHALL enter DEC with rc<=31.
REQ-015 DEC SHALL run one inverse round per cycle: dreg<=InvS(InvP(dreg ^ kreg[79:16])).
REQ-016 In the same DEC cycle, kreg SHALL be inverse-updated: XOR [19:15] with rc, replace [79:76] with InvS(top nibble), rotate right 61; then rc<=rc-1.
REQ-017 When rc=1 in DEC (kreg becomes K1), the block SHALL enter FIN.
REQ-018 In FIN, the block SHALL load odat<=dreg ^ kreg[79:16], pulse done=1 for that cycle, and return to IDLE.
REQ-019 S table (0..F) SHALL be C56B90AD3EF84712.
REQ-020 InvS table (0..F) SHALL be 5EF8C12DB463079A.
REQ-021 InvP SHALL move bit j to position 4j mod 63 for j<63; bit 63 SHALL stay at 63.
REQ-022 Latency: with load sampled at edge 0 and chip_enable held high, odat and done SHALL be valid after edge 63 (31 KEXP + 31 DEC + 1 FIN).
REQ-023 odat SHALL hold its value in IDLE until the next load or reset.
REQ-024 A load during KEXP, DEC or FIN SHALL abort the current operation and restart from REQ-012; no done pulse SHALL occur for the aborted job.
REQ-025 While chip_enable=0: the FSM, rc, dreg, kreg and odat SHALL hold; done SHALL be 0 and busy SHALL hold.
REQ-026 When chip_enable returns high, the block SHALL resume with no lost or duplicated round.
REQ-027 If chip_enable falls in FIN, the done pulse SHALL be deferred to the first enabled cycle.
REQ-028 load=1 with chip_enable=0 SHALL be ignored.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, rc=0, dreg=0, kreg=0, odat=0, done=0, busy=0.
REQ-030 Reset asserted mid-operation SHALL discard the job; no done pulse SHALL follow the release of rst_n.
REQ-031 After reset release, the block SHALL remain in IDLE until a load is sampled.

Verification
REQ-032 key=0, idat=5579C1387B228445, load for 1 cycle -> after 63 cycles done=1 and odat=0000000000000000; busy low the next cycle.
REQ-033 key=FFFFFFFFFFFFFFFFFFFF, idat=E72C46C0F5945049 -> odat=0000000000000000.
REQ-034 key=0, idat=A112FFC72F68417B -> odat=FFFFFFFFFFFFFFFF.
REQ-035 key=all F, idat=3333DCD3213210D2 -> odat=FFFFFFFFFFFFFFFF.
REQ-036 Same as REQ-035 with chip_enable toggled low for 7 random gaps -> same odat; done delayed by exactly the total gap cycles; done never high while chip_enable=0.
REQ-037 Reload at cycle 40 with REQ-033 vector -> no done for the first job; done 63 cycles after reload with odat=0.
REQ-038 rst_n pulse at cycle 20 -> all outputs 0 immediately; no done afterwards.
REQ-039 Loopback: random idat/key through the encryptor then this block -> original plaintext.
